// File: rtl/integral_image_stream_if.sv
// rtl/integral_image_stream_if.sv - pixel stream, query and result bundle for integral_image_stream
interface integral_image_stream_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int SUM_WIDTH   = 20,
  parameter int SQ_WIDTH    = 28,
  parameter int COORD_WIDTH = 8
);
  logic                   start;
  logic [PIXEL_WIDTH-1:0] pix_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [COORD_WIDTH-1:0] q_x1;
  logic [COORD_WIDTH-1:0] q_y1;
  logic [COORD_WIDTH-1:0] q_x2;
  logic [COORD_WIDTH-1:0] q_y2;
  logic                   q_valid;
  logic                   q_ready;
  logic [SUM_WIDTH-1:0]   r_sum;
  logic [SQ_WIDTH-1:0]    r_sqsum;
  logic                   r_err;
  logic                   r_valid;
  logic                   done;

  modport master (
    output start, pix_in, pix_valid, q_x1, q_y1, q_x2, q_y2, q_valid,
    input  pix_ready, q_ready, r_sum, r_sqsum, r_err, r_valid, done
  );

  modport slave (
    input  start, pix_in, pix_valid, q_x1, q_y1, q_x2, q_y2, q_valid,
    output pix_ready, q_ready, r_sum, r_sqsum, r_err, r_valid, done
  );
endinterface

// File: rtl/integral_image_stream.sv
// rtl/integral_image_stream.sv - streaming integral and squared-integral image with pipelined rectangle queries
module integral_image_stream #(
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int PIXEL_WIDTH = 8,
  parameter int SUM_WIDTH   = 20,
  parameter int SQ_WIDTH    = 28,
  parameter int COORD_WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  integral_image_stream_if.slave  bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t state, state_nxt;

  logic [XW-1:0]        x_cnt;
  logic [YW-1:0]        y_cnt;
  logic [SUM_WIDTH-1:0] row_acc;
  logic [SQ_WIDTH-1:0]  rowsq_acc;

  logic [SUM_WIDTH-1:0] ii_mem [IMG_HEIGHT][IMG_WIDTH];
  logic [SQ_WIDTH-1:0]  sq_mem [IMG_HEIGHT][IMG_WIDTH];

  logic                     pix_acc, row_end, last_pix;
  logic [2*PIXEL_WIDTH-1:0] pix_sq;
  logic [SUM_WIDTH-1:0]     row_nxt, ii_val;
  logic [SQ_WIDTH-1:0]      rowsq_nxt, sq_val;
  logic [YW-1:0]            y_prev;

  // a start pulse always wins, so a pixel presented alongside it is dropped
  assign pix_acc  = bus.pix_valid && (state == LOAD) && !bus.start;
  assign row_end  = (x_cnt == XW'(IMG_WIDTH - 1));
  assign last_pix = row_end && (y_cnt == YW'(IMG_HEIGHT - 1));
  assign y_prev   = y_cnt - YW'(1);

  // next integral values: running row sum plus the entry directly above
  always_comb begin
    pix_sq    = {{PIXEL_WIDTH{1'b0}}, bus.pix_in} * {{PIXEL_WIDTH{1'b0}}, bus.pix_in};
    row_nxt   = row_acc + SUM_WIDTH'(bus.pix_in);
    rowsq_nxt = rowsq_acc + SQ_WIDTH'(pix_sq);
    ii_val    = row_nxt;
    sq_val    = rowsq_nxt;
    if (y_cnt != '0) begin
      ii_val = row_nxt + ii_mem[y_prev][x_cnt];
      sq_val = rowsq_nxt + sq_mem[y_prev][x_cnt];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and state-decoded handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.pix_ready = (state == LOAD);
    bus.q_ready   = (state == READY);
    bus.done      = (state == READY);
    if (bus.start)                    state_nxt = LOAD;
    else if (pix_acc && last_pix)     state_nxt = READY;
  end

  // raster counters and per-row accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      row_acc   <= '0;
      rowsq_acc <= '0;
    end else if (bus.start) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      row_acc   <= '0;
      rowsq_acc <= '0;
    end else if (pix_acc) begin
      if (row_end) begin
        x_cnt     <= '0;
        y_cnt     <= last_pix ? '0 : y_cnt + YW'(1);
        row_acc   <= '0;
        rowsq_acc <= '0;
      end else begin
        x_cnt     <= x_cnt + XW'(1);
        row_acc   <= row_nxt;
        rowsq_acc <= rowsq_nxt;
      end
    end
  end

  // table storage; contents are meaningless until a frame completes
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      ii_mem[y_cnt][x_cnt] <= ii_val;
      sq_mem[y_cnt][x_cnt] <= sq_val;
    end
  end

  logic          q_acc, q_err, x1_zero, y1_zero;
  logic [XW-1:0] x1i, x2i, x1m;
  logic [YW-1:0] y1i, y2i, y1m;

  assign q_acc   = bus.q_valid && (state == READY) && !bus.start;
  assign q_err   = (bus.q_x1 > bus.q_x2) || (bus.q_y1 > bus.q_y2) ||
                   (32'(bus.q_x2) >= IMG_WIDTH) || (32'(bus.q_y2) >= IMG_HEIGHT);
  assign x1_zero = (bus.q_x1 == '0);
  assign y1_zero = (bus.q_y1 == '0);
  // out-of-range coordinates only occur with q_err set, where corners are discarded
  assign x1i     = bus.q_x1[XW-1:0];
  assign x2i     = bus.q_x2[XW-1:0];
  assign y1i     = bus.q_y1[YW-1:0];
  assign y2i     = bus.q_y2[YW-1:0];
  assign x1m     = x1i - XW'(1);
  assign y1m     = y1i - YW'(1);

  logic                 s1_valid, s1_err;
  logic [SUM_WIDTH-1:0] s1_a, s1_b, s1_c, s1_d;
  logic [SQ_WIDTH-1:0]  s1_sa, s1_sb, s1_sc, s1_sd;

  // stage 1: fetch the four corners, with any -1 index reading as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_a  <= '0; s1_b  <= '0; s1_c  <= '0; s1_d  <= '0;
      s1_sa <= '0; s1_sb <= '0; s1_sc <= '0; s1_sd <= '0;
    end else begin
      s1_valid <= q_acc;
      if (q_acc) begin
        s1_err <= q_err;
        s1_a   <= ii_mem[y2i][x2i];
        s1_sa  <= sq_mem[y2i][x2i];
        s1_b   <= y1_zero ? '0 : ii_mem[y1m][x2i];
        s1_sb  <= y1_zero ? '0 : sq_mem[y1m][x2i];
        s1_c   <= x1_zero ? '0 : ii_mem[y2i][x1m];
        s1_sc  <= x1_zero ? '0 : sq_mem[y2i][x1m];
        s1_d   <= (x1_zero || y1_zero) ? '0 : ii_mem[y1m][x1m];
        s1_sd  <= (x1_zero || y1_zero) ? '0 : sq_mem[y1m][x1m];
      end
    end
  end

  // stage 2: combine corners; a start pulse drops the result in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r_valid <= 1'b0;
      bus.r_err   <= 1'b0;
      bus.r_sum   <= '0;
      bus.r_sqsum <= '0;
    end else begin
      bus.r_valid <= s1_valid && !bus.start;
      if (s1_valid && !bus.start) begin
        bus.r_err   <= s1_err;
        bus.r_sum   <= s1_err ? '0 : s1_a - s1_b - s1_c + s1_d;
        bus.r_sqsum <= s1_err ? '0 : s1_sa - s1_sb - s1_sc + s1_sd;
      end
    end
  end
endmodule

// File: tb/tb_integral_image_stream.sv
// tb/tb_integral_image_stream.sv - randomized self-checking bench for integral_image_stream
module tb_integral_image_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  integral_image_stream_if if8 ();
  integral_image_stream_if if64 ();

  integral_image_stream #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  integral_image_stream #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(if64)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fr8[64];
  int dq[4][4];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: brute-force rectangle sums over the frame as loaded
  function automatic void model(input int x1, input int y1, input int x2, input int y2,
                                output longint s, output longint sq, output bit err);
    err = (x1 > x2) || (y1 > y2) || (x2 >= 8) || (y2 >= 8);
    s = 0;
    sq = 0;
    if (!err)
      for (int y = y1; y <= y2; y++)
        for (int x = x1; x <= x2; x++) begin
          s  += fr8[y*8+x];
          sq += fr8[y*8+x] * fr8[y*8+x];
        end
    s  = s % (64'd1 << 20);
    sq = sq % (64'd1 << 28);
  endfunction

  // mode: 0 continuous, 1 valid toggling, 2 random gaps
  task automatic load8(input int n_pix, input int mode);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit tog = 1'b0;
    if8.start = 1'b1;
    if8.pix_valid = 1'b1;
    if8.pix_in = 8'd200;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.pix_valid = 1'b0;
    check("done_drops_after_start", if8.done, 0);
    check("pix_ready_after_start", if8.pix_ready, 1);
    while (idx < n_pix && cyc < 2000) begin
      if8.pix_in = 8'(fr8[idx]);
      case (mode)
        0:       if8.pix_valid = 1'b1;
        1:       if8.pix_valid = tog;
        default: if8.pix_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      acc = if8.pix_valid && if8.pix_ready;
      if (n_pix == 64 && idx == 63 && acc) check("done_before_last", if8.done, 0);
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    if8.pix_valid = 1'b0;
    check("load_count", idx, n_pix);
    if (n_pix == 64) begin
      check("done_after_last", if8.done, 1);
      check("q_ready_after_last", if8.q_ready, 1);
    end
  endtask

  task automatic query8(input int x1, input int y1, input int x2, input int y2,
                        output longint gs, output longint gq, output bit ge);
    longint es, eq;
    bit ee;
    model(x1, y1, x2, y2, es, eq, ee);
    if8.q_x1 = 8'(x1); if8.q_y1 = 8'(y1); if8.q_x2 = 8'(x2); if8.q_y2 = 8'(y2);
    if8.q_valid = 1'b1;
    @(posedge clk); #1;
    if8.q_valid = 1'b0;
    check("q_latency_early", if8.r_valid, 0);
    @(posedge clk); #1;
    check("q_valid_at_2", if8.r_valid, 1);
    check("q_sum", if8.r_sum, es);
    check("q_sqsum", if8.r_sqsum, eq);
    check("q_err", if8.r_err, ee);
    gs = if8.r_sum;
    gq = if8.r_sqsum;
    ge = if8.r_err;
    @(posedge clk); #1;
    check("q_pulse_single", if8.r_valid, 0);
  endtask

  task automatic burst8(input int n, input bit rnd);
    longint es[$];
    longint eq[$];
    bit ee[$];
    int issued = 0;
    int pulses = 0;
    int idle = 0;
    int x1, y1, x2, y2;
    longint s, sq;
    bit e;
    for (int c = 0; c < n * 4 + 10 && idle < 4; c++) begin
      if (issued < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (rnd) begin
          x1 = $urandom_range(0, 9); y1 = $urandom_range(0, 9);
          x2 = $urandom_range(0, 9); y2 = $urandom_range(0, 9);
        end else begin
          x1 = dq[issued][0]; y1 = dq[issued][1]; x2 = dq[issued][2]; y2 = dq[issued][3];
        end
        if8.q_x1 = 8'(x1); if8.q_y1 = 8'(y1); if8.q_x2 = 8'(x2); if8.q_y2 = 8'(y2);
        if8.q_valid = 1'b1;
        model(x1, y1, x2, y2, s, sq, e);
        es.push_back(s);
        eq.push_back(sq);
        ee.push_back(e);
        issued++;
      end else begin
        if8.q_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (issued == n) idle++;
      if (if8.r_valid) begin
        pulses++;
        if (es.size() == 0) check("burst_extra_pulse", 1, 0);
        else begin
          check("burst_sum", if8.r_sum, es.pop_front());
          check("burst_sqsum", if8.r_sqsum, eq.pop_front());
          check("burst_err", if8.r_err, ee.pop_front());
        end
      end
    end
    if8.q_valid = 1'b0;
    check("burst_pulses", pulses, n);
    check("burst_pending", es.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint gs, gq;
    bit ge;
    int idx, cyc, pulses;
    if8.start = 0; if8.pix_in = 0; if8.pix_valid = 0;
    if8.q_x1 = 0; if8.q_y1 = 0; if8.q_x2 = 0; if8.q_y2 = 0; if8.q_valid = 0;
    if64.start = 0; if64.pix_in = 0; if64.pix_valid = 0;
    if64.q_x1 = 0; if64.q_y1 = 0; if64.q_x2 = 0; if64.q_y2 = 0; if64.q_valid = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", if8.pix_ready, 0);
    check("rst_q_ready", if8.q_ready, 0);
    check("rst_done", if8.done, 0);
    check("rst_r_valid", if8.r_valid, 0);
    check("rst_r_err", if8.r_err, 0);
    check("rst_r_sum", if8.r_sum, 0);
    check("rst_r_sqsum", if8.r_sqsum, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all ones
    for (int i = 0; i < 64; i++) fr8[i] = 1;
    load8(64, 0);
    query8(0, 0, 7, 7, gs, gq, ge);
    check("ones_full_sum", gs, 64);
    check("ones_full_sq", gq, 64);
    query8(3, 3, 3, 3, gs, gq, ge);
    check("ones_pt_sum", gs, 1);
    check("ones_pt_sq", gq, 1);

    // pixel = x + y with valid toggling
    for (int i = 0; i < 64; i++) fr8[i] = (i % 8) + (i / 8);
    load8(64, 1);
    query8(2, 3, 4, 5, gs, gq, ge);
    check("xy_rect_sum", gs, 63);
    check("xy_rect_sq", gq, 453);
    query8(0, 0, 0, 0, gs, gq, ge);
    check("xy_origin_sum", gs, 0);
    check("xy_origin_sq", gq, 0);

    // back-to-back with two invalid queries
    dq[0] = '{0, 0, 7, 7};
    dq[1] = '{5, 0, 2, 7};
    dq[2] = '{0, 0, 8, 0};
    dq[3] = '{1, 2, 3, 4};
    burst8(4, 1'b0);

    // restart mid-load, then a frame of twos
    for (int i = 0; i < 64; i++) fr8[i] = $urandom_range(0, 255);
    load8(20, 2);
    for (int i = 0; i < 64; i++) fr8[i] = 2;
    load8(64, 0);
    query8(0, 0, 7, 7, gs, gq, ge);
    check("twos_full_sum", gs, 128);

    // random frames with random gaps and random query bursts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) fr8[i] = $urandom_range(0, 255);
      load8(64, 2);
      burst8(16, 1'b1);
    end

    // asynchronous reset in the middle of a query stream
    query8(1, 1, 5, 5, gs, gq, ge);
    if8.q_x1 = 0; if8.q_y1 = 0; if8.q_x2 = 7; if8.q_y2 = 7;
    if8.q_valid = 1'b1;
    @(posedge clk); #1;
    if8.q_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_r_valid", if8.r_valid, 0);
    check("arst_r_sum", if8.r_sum, 0);
    check("arst_r_sqsum", if8.r_sqsum, 0);
    check("arst_r_err", if8.r_err, 0);
    check("arst_done", if8.done, 0);
    check("arst_q_ready", if8.q_ready, 0);
    check("arst_pix_ready", if8.pix_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if8.q_valid = 1'b1;
      @(posedge clk); #1;
      if (if8.r_valid) pulses++;
    end
    if8.q_valid = 1'b0;
    check("arst_no_pulse", pulses, 0);
    check("arst_needs_reload", if8.q_ready, 0);

    // full 64x64 frame of 255
    if64.start = 1'b1;
    @(posedge clk); #1;
    if64.start = 1'b0;
    idx = 0;
    cyc = 0;
    if64.pix_in = 8'd255;
    if64.pix_valid = 1'b1;
    while (idx < 4096 && cyc < 10000) begin
      @(posedge clk); #1;
      cyc++;
      idx++;
    end
    if64.pix_valid = 1'b0;
    check("big_done", if64.done, 1);
    if64.q_x1 = 0; if64.q_y1 = 0; if64.q_x2 = 63; if64.q_y2 = 63;
    if64.q_valid = 1'b1;
    @(posedge clk); #1;
    if64.q_x1 = 10; if64.q_y1 = 20; if64.q_x2 = 40; if64.q_y2 = 33;
    @(posedge clk); #1;
    if64.q_valid = 1'b0;
    check("big_full_valid", if64.r_valid, 1);
    check("big_full_sum", if64.r_sum, 1044480);
    check("big_full_sq", if64.r_sqsum, 266342400);
    check("big_full_err", if64.r_err, 0);
    @(posedge clk); #1;
    check("big_sub_valid", if64.r_valid, 1);
    check("big_sub_sum", if64.r_sum, 31 * 14 * 255);
    check("big_sub_sq", if64.r_sqsum, 31 * 14 * 255 * 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
